// File: rtl/ultrasonido_filtro_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ultrasonido_filtro_pkg
// Brief    : Shared constants, state encodings and helpers for the ultrasonic
//            distance filter (count -> cm conversion, averaging, near flag).
// Revision : 1.0 - initial release
// ============================================================================
package ultrasonido_filtro_pkg;

  // Width of every distance value in centimetres (0..511)
  localparam int DIST_W = 9;

  // Defaults for a 50 MHz clock and 343 m/s round-trip echo
  localparam int MAX_CM_DEF        = 450;
  localparam int CICLOS_POR_CM_DEF = 2915;

  // Sample-processing FSM encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_ACCUM  = 2'd2;
  localparam logic [1:0] ST_OUTPUT = 2'd3;

  typedef logic [DIST_W-1:0] dist_t;

  // Clamp a raw quotient to the saturation distance before narrowing it,
  // so quotients above 511 can never alias into a small distance.
  function automatic dist_t satura_cm(input logic [31:0] q, input logic [31:0] max_cm);
    if (q > max_cm) begin
      return max_cm[DIST_W-1:0];
    end
    return q[DIST_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ultrasonido_filtro_div_restaurador.sv
`default_nettype none
// ============================================================================
// Module   : div_restaurador
// Brief    : Sequential restoring divider, one quotient bit per cycle, MSB
//            first. start loads operands; done marks the cycle whose closing
//            edge writes the last quotient bit, so cociente is final from the
//            following cycle until the next start.
// Revision : 1.0 - initial release
// ============================================================================
module div_restaurador
  import ultrasonido_filtro_pkg::*;
#(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividendo,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] cociente
);

  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] C_ULTIMO = CNT_W'(W - 1);

  logic [W-1:0]     dvd_q, dvd_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [W:0]       trial;
  logic [W-1:0]     diff;
  logic             ge;

  // One restoring step per cycle: shift in next dividend bit, subtract if it fits
  always_comb begin
    trial  = {rem_q, dvd_q[W-1]};
    diff   = trial[W-1:0] - dvs_q;
    ge     = (trial >= {1'b0, dvs_q});
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      dvd_d  = dividendo;
      dvs_d  = divisor;
      rem_d  = '0;
      quo_d  = '0;
      cnt_d  = C_ULTIMO;
      busy_d = 1'b1;
    end else if (busy_q) begin
      dvd_d = {dvd_q[W-2:0], 1'b0};
      rem_d = ge ? diff : trial[W-1:0];
      quo_d = {quo_q[W-2:0], ge};
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done     = busy_q && (cnt_q == '0);
  assign cociente = quo_q;

endmodule
`default_nettype wire

// File: rtl/ultrasonido_filtro.sv
`default_nettype none
// ============================================================================
// Module   : ultrasonido_filtro
// Brief    : Converts echo-width counts to centimetres, keeps a moving
//            average, and drives a hysteretic near flag plus a
//            persistence-qualified alert.
// Revision : 1.0 - initial release
// ============================================================================
module ultrasonido_filtro
  import ultrasonido_filtro_pkg::*;
#(
  parameter int CUENTA_W      = 22,
  parameter int CICLOS_POR_CM = CICLOS_POR_CM_DEF,
  parameter int MAX_CM        = MAX_CM_DEF,
  parameter int PROM_LOG2     = 2,
  parameter int UMBRAL_CERCA  = 20,
  parameter int UMBRAL_LEJOS  = 30,
  parameter int PERSIST_CYC   = 50000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                muestra_valid,
  input  logic                timeout,
  input  logic [CUENTA_W-1:0] cuenta_echo,
  output logic                ocupado,
  output logic                dist_valid,
  output logic [DIST_W-1:0]   distancia_cm,
  output logic [DIST_W-1:0]   promedio_cm,
  output logic                cerca,
  output logic                alerta,
  output logic                perdida
);

  localparam int PROFUND = 2 ** PROM_LOG2;
  localparam int SUM_W   = DIST_W + PROM_LOG2;
  localparam int PERS_W  = $clog2(PERSIST_CYC + 1);

  localparam logic [DIST_W-1:0]   C_MAX_CM   = DIST_W'(MAX_CM);
  localparam logic [DIST_W-1:0]   C_CERCA    = DIST_W'(UMBRAL_CERCA);
  localparam logic [DIST_W-1:0]   C_LEJOS    = DIST_W'(UMBRAL_LEJOS);
  localparam logic [SUM_W-1:0]    C_SUM_INI  = SUM_W'(MAX_CM * PROFUND);
  localparam logic [PERS_W-1:0]   C_PERS_MAX = PERS_W'(PERSIST_CYC);
  localparam logic [CUENTA_W-1:0] C_DIVISOR  = CUENTA_W'(CICLOS_POR_CM);

  logic [1:0]           state_q, state_d;
  logic                 tmo_q, tmo_d;
  logic                 dist_valid_q, dist_valid_d;
  dist_t                distancia_q, distancia_d;
  dist_t                promedio_q, promedio_d;
  logic                 cerca_q, cerca_d;
  logic                 perdida_q, perdida_d;
  logic [PERS_W-1:0]    pers_q, pers_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [PROM_LOG2-1:0] ptr_q, ptr_d;
  dist_t                buf_q [PROFUND];
  dist_t                buf_d [PROFUND];

  logic                 div_start;
  logic                 div_done;
  logic [CUENTA_W-1:0]  div_cociente;
  dist_t                dist_nueva;
  dist_t                prom_nuevo;

  div_restaurador #(
    .W (CUENTA_W)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividendo (cuenta_echo),
    .divisor   (C_DIVISOR),
    .done      (div_done),
    .cociente  (div_cociente)
  );

  // Sample FSM, averaging buffer, hysteresis and lost-sample tracking
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    dist_valid_d = 1'b0;
    distancia_d  = distancia_q;
    promedio_d   = promedio_q;
    cerca_d      = cerca_q;
    sum_d        = sum_q;
    ptr_d        = ptr_q;
    buf_d        = buf_q;
    div_start    = 1'b0;
    // A pulse that arrives while busy is dropped but remembered
    perdida_d    = perdida_q | ((muestra_valid | timeout) & (state_q != ST_IDLE));
    dist_nueva   = tmo_q ? C_MAX_CM : satura_cm(32'(div_cociente), 32'(MAX_CM));
    prom_nuevo   = DIST_W'(sum_q >> PROM_LOG2);

    case (state_q)
      ST_IDLE: begin
        // Timeout takes priority and bypasses the divider entirely
        if (timeout) begin
          tmo_d   = 1'b1;
          state_d = ST_ACCUM;
        end else if (muestra_valid) begin
          tmo_d     = 1'b0;
          div_start = 1'b1;
          state_d   = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        if (div_done) begin
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // Running sum swaps the oldest entry for the newest one
        distancia_d  = dist_nueva;
        sum_d        = sum_q - SUM_W'(buf_q[ptr_q]) + SUM_W'(dist_nueva);
        buf_d[ptr_q] = dist_nueva;
        ptr_d        = ptr_q + 1'b1;
        state_d      = ST_OUTPUT;
      end
      default: begin
        dist_valid_d = 1'b1;
        promedio_d   = prom_nuevo;
        if (prom_nuevo <= C_CERCA) begin
          cerca_d = 1'b1;
        end else if (prom_nuevo >= C_LEJOS) begin
          cerca_d = 1'b0;
        end
        state_d = ST_IDLE;
      end
    endcase
  end

  // Persistence counter: runs while near, saturates, clears once near drops
  always_comb begin
    pers_d = '0;
    if (cerca_q) begin
      pers_d = (pers_q == C_PERS_MAX) ? pers_q : pers_q + 1'b1;
    end
  end

  // State registers with synchronous reset to the far/idle condition
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tmo_q        <= 1'b0;
      dist_valid_q <= 1'b0;
      distancia_q  <= C_MAX_CM;
      promedio_q   <= C_MAX_CM;
      cerca_q      <= 1'b0;
      perdida_q    <= 1'b0;
      pers_q       <= '0;
      sum_q        <= C_SUM_INI;
      ptr_q        <= '0;
      for (int i = 0; i < PROFUND; i++) begin
        buf_q[i] <= C_MAX_CM;
      end
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      dist_valid_q <= dist_valid_d;
      distancia_q  <= distancia_d;
      promedio_q   <= promedio_d;
      cerca_q      <= cerca_d;
      perdida_q    <= perdida_d;
      pers_q       <= pers_d;
      sum_q        <= sum_d;
      ptr_q        <= ptr_d;
      buf_q        <= buf_d;
    end
  end

  assign ocupado      = (state_q != ST_IDLE);
  assign dist_valid   = dist_valid_q;
  assign distancia_cm = distancia_q;
  assign promedio_cm  = promedio_q;
  assign cerca        = cerca_q;
  // Gating with cerca makes the alert fall in the same cycle as the flag
  assign alerta       = cerca_q && (pers_q == C_PERS_MAX);
  assign perdida      = perdida_q;

endmodule
`default_nettype wire
